rob_completion: RTL and testbench

- In-order completion and retirement buffer (ROB) sitting downstream of the execute stage.
- Allocates entries for up to MACHINE_WIDTH renamed instructions per cycle.
- Marks entries complete from the ISSUE_WIDTH-wide CDB writeback broadcast.
- Retires up to MACHINE_WIDTH oldest completed entries per cycle, returning old PRNs to the free list. Raises rs_nuke on a retiring mispredict.

---
 rtl/rob_completion_if.sv | 54 +++++
 rtl/rob_completion.sv | 196 +++++++++++++++++++
 tb/tb_rob_completion.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_completion_if.sv
// Bus bundle for rob_completion: dispatch allocation, CDB writeback, retirement and debug state.
// The ROB side uses the slave modport; the dispatch/execute/free-list side uses master.
interface rob_completion_if #(
  parameter int ROB_DEPTH     = 64,
  parameter int MACHINE_WIDTH = 3,
  parameter int ISSUE_WIDTH   = 7,
  parameter int PRF_WIDTH     = 7,
  parameter int ARF_WIDTH     = 5
);
  localparam int ROBW = $clog2(ROB_DEPTH);

  // Handshakes carry no ready: an allocation group is taken whole at the edge when it fits in
  // rob_avail_cnt and silently dropped otherwise (dispatch gates on rob_full); CDB and retire
  // lanes are single-cycle valid pulses that the receiver always consumes.
  logic [MACHINE_WIDTH-1:0]           alloc_valid;
  logic [MACHINE_WIDTH*ARF_WIDTH-1:0] alloc_dest_arn;
  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] alloc_dest_prn;
  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] alloc_old_prn;
  logic [MACHINE_WIDTH-1:0]           alloc_halt;
  logic [MACHINE_WIDTH*ROBW-1:0]      alloc_rob_entry;
  logic [ROBW:0]                      rob_avail_cnt;
  logic                               rob_full;

  logic [ISSUE_WIDTH-1:0]             cdb_valid;
  logic [ISSUE_WIDTH*ROBW-1:0]        cdb_rob_entry;
  logic [ISSUE_WIDTH-1:0]             cdb_mispredict;

  logic [MACHINE_WIDTH-1:0]           retire_valid;
  logic [MACHINE_WIDTH*ARF_WIDTH-1:0] retire_dest_arn;
  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] retire_dest_prn;
  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] retire_old_prn;
  logic                               retire_halt;
  logic                               rs_nuke;

  logic [ROBW-1:0]                    dbg_head;
  logic [ROBW:0]                      dbg_count;
  logic                               dbg_halted;

  modport master (
    output alloc_valid, alloc_dest_arn, alloc_dest_prn, alloc_old_prn, alloc_halt,
    output cdb_valid, cdb_rob_entry, cdb_mispredict,
    input  alloc_rob_entry, rob_avail_cnt, rob_full,
    input  retire_valid, retire_dest_arn, retire_dest_prn, retire_old_prn, retire_halt, rs_nuke,
    input  dbg_head, dbg_count, dbg_halted
  );

  modport slave (
    input  alloc_valid, alloc_dest_arn, alloc_dest_prn, alloc_old_prn, alloc_halt,
    input  cdb_valid, cdb_rob_entry, cdb_mispredict,
    output alloc_rob_entry, rob_avail_cnt, rob_full,
    output retire_valid, retire_dest_arn, retire_dest_prn, retire_old_prn, retire_halt, rs_nuke,
    output dbg_head, dbg_count, dbg_halted
  );
endinterface

// File: rtl/rob_completion.sv
// In-order completion/retirement buffer: allocates, marks complete from the CDB, retires in order.
// Define ROB_CDB_BYPASS_EN to let retire select see same-cycle CDB completions.
module rob_completion #(
  parameter int ROB_DEPTH     = 64,
  parameter int MACHINE_WIDTH = 3,
  parameter int ISSUE_WIDTH   = 7,
  parameter int PRF_WIDTH     = 7,
  parameter int ARF_WIDTH     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  rob_completion_if.slave bus
);
  localparam int ROBW = $clog2(ROB_DEPTH);
  localparam int MW   = MACHINE_WIDTH;
  localparam int IW   = ISSUE_WIDTH;

  typedef logic [ROBW-1:0] idx_t;
  typedef logic [ROBW:0]   cnt_t;

  idx_t head_q, tail_q;
  cnt_t count_q, avail_q;
  logic full_q, halted_q;
  logic [ROB_DEPTH-1:0] valid_q, complete_q, mispred_q, halt_q;

  logic [ARF_WIDTH-1:0] arn_mem [ROB_DEPTH];
  logic [PRF_WIDTH-1:0] prn_mem [ROB_DEPTH];
  logic [PRF_WIDTH-1:0] old_mem [ROB_DEPTH];

  logic [MW-1:0]           ret_valid_q;
  logic [MW*ARF_WIDTH-1:0] ret_arn_q;
  logic [MW*PRF_WIDTH-1:0] ret_prn_q, ret_old_q;
  logic                    ret_halt_q, nuke_q;

  idx_t alloc_idx [MW];
  idx_t ret_idx   [MW];
  idx_t cdb_idx   [IW];

  for (genvar g = 0; g < MW; g++) begin : g_lane
    assign alloc_idx[g] = tail_q + idx_t'(g);
    assign ret_idx[g]   = head_q + idx_t'(g);
    assign bus.alloc_rob_entry[g*ROBW +: ROBW] = alloc_idx[g];
  end

  for (genvar g = 0; g < IW; g++) begin : g_cdb
    assign cdb_idx[g] = bus.cdb_rob_entry[g*ROBW +: ROBW];
  end

  // Effective completion state of the MW oldest entries as seen by retire select.
  logic [MW-1:0] lane_done, lane_misp;
  always_comb begin
    lane_done = '0;
    lane_misp = '0;
    for (int i = 0; i < MW; i++) begin
      lane_done[i] = complete_q[ret_idx[i]];
      lane_misp[i] = mispred_q[ret_idx[i]];
`ifdef ROB_CDB_BYPASS_EN
      for (int p = 0; p < IW; p++) begin
        if (bus.cdb_valid[p] && cdb_idx[p] == ret_idx[i]) begin
          lane_done[i] = 1'b1;
          lane_misp[i] = lane_misp[i] | bus.cdb_mispredict[p];
        end
      end
`endif
    end
  end

  // Retire a contiguous run from head; a mispredict or halt ends the run after itself.
  logic [MW-1:0] ret_lane;
  cnt_t          ret_k;
  logic          ret_nuke, ret_halt, ret_stop;
  always_comb begin
    ret_lane = '0;
    ret_k    = '0;
    ret_nuke = 1'b0;
    ret_halt = 1'b0;
    ret_stop = halted_q;
    for (int i = 0; i < MW; i++) begin
      if (!ret_stop && valid_q[ret_idx[i]] && lane_done[i]) begin
        ret_lane[i] = 1'b1;
        ret_k       = ret_k + cnt_t'(1);
        if (lane_misp[i]) begin
          ret_nuke = 1'b1;
          ret_stop = 1'b1;
        end
        if (halt_q[ret_idx[i]]) begin
          ret_halt = 1'b1;
          ret_stop = 1'b1;
        end
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  cnt_t alloc_n, accepted_n, count_next, avail_next;
  logic alloc_ok;
  idx_t head_next;
  always_comb begin
    alloc_n = '0;
    for (int i = 0; i < MW; i++) alloc_n = alloc_n + cnt_t'(bus.alloc_valid[i]);
  end

  // A retiring mispredict squashes everything younger, including this edge's allocation.
  assign alloc_ok   = (alloc_n <= avail_q) && !ret_nuke;
  assign accepted_n = alloc_ok ? alloc_n : '0;
  assign head_next  = head_q + ret_k[ROBW-1:0];
  assign count_next = ret_nuke ? '0 : (count_q + accepted_n - ret_k);
  assign avail_next = cnt_t'(ROB_DEPTH) - count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      avail_q     <= cnt_t'(ROB_DEPTH);
      full_q      <= 1'b0;
      halted_q    <= 1'b0;
      valid_q     <= '0;
      complete_q  <= '0;
      mispred_q   <= '0;
      halt_q      <= '0;
      ret_valid_q <= '0;
      ret_arn_q   <= '0;
      ret_prn_q   <= '0;
      ret_old_q   <= '0;
      ret_halt_q  <= 1'b0;
      nuke_q      <= 1'b0;
    end else begin
      head_q  <= head_next;
      count_q <= count_next;
      avail_q <= avail_next;
      full_q  <= avail_next < cnt_t'(MW);
      if (ret_halt) halted_q <= 1'b1;

      if (ret_nuke) begin
        tail_q  <= head_next;
        valid_q <= '0;
      end else begin
        for (int i = 0; i < MW; i++)
          if (ret_lane[i]) valid_q[ret_idx[i]] <= 1'b0;
        for (int p = 0; p < IW; p++) begin
          if (bus.cdb_valid[p] && valid_q[cdb_idx[p]]) begin
            complete_q[cdb_idx[p]] <= 1'b1;
            if (bus.cdb_mispredict[p]) mispred_q[cdb_idx[p]] <= 1'b1;
          end
        end
        if (alloc_ok) begin
          tail_q <= tail_q + alloc_n[ROBW-1:0];
          for (int i = 0; i < MW; i++) begin
            if (bus.alloc_valid[i]) begin
              valid_q[alloc_idx[i]]    <= 1'b1;
              complete_q[alloc_idx[i]] <= 1'b0;
              mispred_q[alloc_idx[i]]  <= 1'b0;
              halt_q[alloc_idx[i]]     <= bus.alloc_halt[i];
            end
          end
        end
      end

      ret_valid_q <= ret_lane;
      ret_halt_q  <= ret_halt;
      nuke_q      <= ret_nuke;
      for (int i = 0; i < MW; i++) begin
        ret_arn_q[i*ARF_WIDTH +: ARF_WIDTH] <= ret_lane[i] ? arn_mem[ret_idx[i]] : '0;
        ret_prn_q[i*PRF_WIDTH +: PRF_WIDTH] <= ret_lane[i] ? prn_mem[ret_idx[i]] : '0;
        ret_old_q[i*PRF_WIDTH +: PRF_WIDTH] <= ret_lane[i] ? old_mem[ret_idx[i]] : '0;
      end
    end
  end

  // Payload is only read behind a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      for (int i = 0; i < MW; i++) begin
        if (bus.alloc_valid[i]) begin
          arn_mem[alloc_idx[i]] <= bus.alloc_dest_arn[i*ARF_WIDTH +: ARF_WIDTH];
          prn_mem[alloc_idx[i]] <= bus.alloc_dest_prn[i*PRF_WIDTH +: PRF_WIDTH];
          old_mem[alloc_idx[i]] <= bus.alloc_old_prn[i*PRF_WIDTH +: PRF_WIDTH];
        end
      end
    end
  end

  assign bus.rob_avail_cnt   = avail_q;
  assign bus.rob_full        = full_q;
  assign bus.retire_valid    = ret_valid_q;
  assign bus.retire_dest_arn = ret_arn_q;
  assign bus.retire_dest_prn = ret_prn_q;
  assign bus.retire_old_prn  = ret_old_q;
  assign bus.retire_halt     = ret_halt_q;
  assign bus.rs_nuke         = nuke_q;
  assign bus.dbg_head        = head_q;
  assign bus.dbg_count       = count_q;
  assign bus.dbg_halted      = halted_q;
endmodule

// File: tb/tb_rob_completion.sv
// Self-checking bench for rob_completion: table-driven fill/overflow plus hand-written
// latency, wrap, mispredict and halt sequences; retired payload checked against a queue.
module tb_rob_completion;
  localparam int MW    = 3;
  localparam int IW    = 7;
  localparam int PW    = 7;
  localparam int AW    = 5;
  localparam int DEPTH = 64;
  localparam int RW    = 6;
  localparam int W     = AW + 2*PW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_completion_if bus ();
  rob_completion dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int ptr   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [MW-1:0] v;
    bit            accept;
    int            exp_entry0;
    int            exp_avail;
    logic          exp_full;
  } vec_t;
  vec_t tbl [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid    = '0;
    bus.alloc_dest_arn = '0;
    bus.alloc_dest_prn = '0;
    bus.alloc_old_prn  = '0;
    bus.alloc_halt     = '0;
    bus.cdb_valid      = '0;
    bus.cdb_rob_entry  = '0;
    bus.cdb_mispredict = '0;
  endtask

  task automatic drive_alloc(input logic [MW-1:0] v, input bit accept, input logic [MW-1:0] halt);
    logic [AW-1:0] arn;
    logic [PW-1:0] prn, old;
    for (int i = 0; i < MW; i++) begin
      arn = AW'($urandom_range(0, 31));
      prn = PW'($urandom_range(0, 127));
      old = PW'($urandom_range(0, 127));
      bus.alloc_dest_arn[i*AW +: AW] = arn;
      bus.alloc_dest_prn[i*PW +: PW] = prn;
      bus.alloc_old_prn[i*PW +: PW]  = old;
      if (v[i] && accept) exp_q.push_back({arn, prn, old});
    end
    bus.alloc_valid = v;
    bus.alloc_halt  = halt;
  endtask

  task automatic complete_range(input int start, input int num);
    int done = 0;
    while (done < num) begin
      bus.cdb_valid      = '0;
      bus.cdb_mispredict = '0;
      for (int p = 0; p < IW && done < num; p++) begin
        bus.cdb_valid[p] = 1'b1;
        bus.cdb_rob_entry[p*RW +: RW] = RW'((start + done) % DEPTH);
        done++;
      end
      step();
    end
    bus.cdb_valid = '0;
  endtask

  task automatic wait_drained(input string name);
    for (int c = 0; c < 60; c++) begin
      if (bus.rob_avail_cnt == DEPTH && bus.retire_valid == '0) break;
      step();
    end
    check(name, bus.rob_avail_cnt, DEPTH);
  endtask

  // Allocate and retire num entries so that head and tail move forward by num.
  task automatic advance(input int num);
    int rem = num;
    int lanes;
    while (rem > 0) begin
      lanes = (rem > MW) ? MW : rem;
      drive_alloc(MW'((1 << lanes) - 1), 1'b1, '0);
      step();
      idle_inputs();
      rem -= lanes;
    end
    complete_range(ptr, num);
    wait_drained("advance_drain");
    ptr = (ptr + num) % DEPTH;
    check("advance_head", bus.dbg_head, ptr);
  endtask

  // Retired lanes are compared in order; a nuke squashes everything still expected.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < MW; i++) begin
        if (bus.retire_valid[i]) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL retire_unexpected: lane %0d retired with nothing expected", i);
          end else begin
            logic [W-1:0] exp_r, got_r;
            exp_r = exp_q.pop_front();
            got_r = {bus.retire_dest_arn[i*AW +: AW], bus.retire_dest_prn[i*PW +: PW],
                     bus.retire_old_prn[i*PW +: PW]};
            if (got_r !== exp_r) begin
              n_bad++;
              $display("FAIL retire_payload: lane %0d got %h expected %h", i, got_r, exp_r);
            end
          end
        end
      end
      if (bus.rs_nuke) exp_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 21; i++) begin
      tbl[i].v          = 3'b111;
      tbl[i].accept     = 1'b1;
      tbl[i].exp_entry0 = (3 + 3*i) % DEPTH;
      tbl[i].exp_avail  = DEPTH - 3*(i + 1);
      tbl[i].exp_full   = (DEPTH - 3*(i + 1)) < MW;
    end
    tbl[21] = '{v: 3'b001, accept: 1'b1, exp_entry0: 2, exp_avail: 0, exp_full: 1'b1};
    tbl[22] = '{v: 3'b011, accept: 1'b0, exp_entry0: 3, exp_avail: 0, exp_full: 1'b1};
    tbl[23] = '{v: 3'b000, accept: 1'b0, exp_entry0: 3, exp_avail: 0, exp_full: 1'b1};
    tbl[24] = '{v: 3'b111, accept: 1'b0, exp_entry0: 3, exp_avail: 0, exp_full: 1'b1};

    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_avail", bus.rob_avail_cnt, 64);
    check("rst_full", bus.rob_full, 0);
    check("rst_retire_valid", bus.retire_valid, 0);
    check("rst_nuke", bus.rs_nuke, 0);
    check("rst_old_prn", bus.retire_old_prn, 0);
    check("rst_entries", bus.alloc_rob_entry, {6'd2, 6'd1, 6'd0});

    // Out-of-order completion: entry 0 retires alone, then 1 and 2 together.
    drive_alloc(3'b111, 1'b1, '0);
    check("seq_entries", bus.alloc_rob_entry, {6'd2, 6'd1, 6'd0});
    step();
    idle_inputs();
    check("seq_avail", bus.rob_avail_cnt, 61);
    bus.cdb_valid = 7'b0000001; bus.cdb_rob_entry[RW-1:0] = 6'd2;
    step();
    check("seq_ret_a", bus.retire_valid, 3'b000);
    bus.cdb_rob_entry[RW-1:0] = 6'd0;
    step();
`ifdef ROB_CDB_BYPASS_EN
    check("seq_ret_b", bus.retire_valid, 3'b001);
`else
    check("seq_ret_b", bus.retire_valid, 3'b000);
`endif
    bus.cdb_rob_entry[RW-1:0] = 6'd1;
    step();
    bus.cdb_valid = '0;
`ifdef ROB_CDB_BYPASS_EN
    check("seq_ret_c", bus.retire_valid, 3'b011);
    step();
    check("seq_ret_d", bus.retire_valid, 3'b000);
`else
    check("seq_ret_c", bus.retire_valid, 3'b001);
    step();
    check("seq_ret_d", bus.retire_valid, 3'b011);
`endif
    step();
    check("seq_ret_idle", bus.retire_valid, 3'b000);
    check("seq_avail_end", bus.rob_avail_cnt, 64);
    ptr = 3;
    check("seq_head", bus.dbg_head, ptr);

    // Fill to full, then overflowing groups are dropped whole.
    for (int r = 0; r < 25; r++) begin
      drive_alloc(tbl[r].v, tbl[r].accept, '0);
      check("tbl_entry0", bus.alloc_rob_entry[RW-1:0], tbl[r].exp_entry0);
      step();
      idle_inputs();
      check("tbl_avail", bus.rob_avail_cnt, tbl[r].exp_avail);
      check("tbl_full", bus.rob_full, tbl[r].exp_full);
    end
    complete_range(3, 64);
    wait_drained("full_drain");
    check("full_queue_empty", exp_q.size(), 0);
    check("full_head", bus.dbg_head, 3);

    // Pointer wrap around the end of the buffer.
    advance(59);
    drive_alloc(3'b111, 1'b1, '0);
    check("wrap_entries", bus.alloc_rob_entry, {6'd0, 6'd63, 6'd62});
    step();
    idle_inputs();
    check("wrap_tail", bus.alloc_rob_entry[RW-1:0], 1);
    complete_range(62, 3);
`ifndef ROB_CDB_BYPASS_EN
    check("wrap_ret_wait", bus.retire_valid, 3'b000);
    step();
`endif
    check("wrap_ret", bus.retire_valid, 3'b111);
    check("wrap_avail", bus.rob_avail_cnt, 64);
    check("wrap_head", bus.dbg_head, 1);
    step();
    ptr = 1;

    // Mispredict at head 5 with a same-edge allocation that must be dropped.
    advance(4);
    drive_alloc(3'b111, 1'b1, '0);
    step();
    idle_inputs();
    bus.cdb_valid = 7'b0000011;
    bus.cdb_rob_entry[RW-1:0] = 6'd6;
    bus.cdb_rob_entry[2*RW-1:RW] = 6'd7;
    step();
    bus.cdb_valid = 7'b0000001;
    bus.cdb_rob_entry[RW-1:0] = 6'd5;
    bus.cdb_mispredict = 7'b0000001;
`ifdef ROB_CDB_BYPASS_EN
    drive_alloc(3'b111, 1'b0, '0);
    step();
    idle_inputs();
`else
    step();
    idle_inputs();
    check("misp_ret_wait", bus.retire_valid, 3'b000);
    drive_alloc(3'b111, 1'b0, '0);
    step();
    idle_inputs();
`endif
    check("misp_ret", bus.retire_valid, 3'b001);
    check("misp_nuke", bus.rs_nuke, 1);
    check("misp_avail", bus.rob_avail_cnt, 64);
    step();
    check("misp_nuke_off", bus.rs_nuke, 0);
    check("misp_ret_off", bus.retire_valid, 3'b000);
    check("misp_avail_after", bus.rob_avail_cnt, 64);
    check("misp_tail", bus.alloc_rob_entry[RW-1:0], 6);
    check("misp_queue_empty", exp_q.size(), 0);
    ptr = 6;

    // Single entry at head: completion-to-retire latency.
    drive_alloc(3'b001, 1'b1, '0);
    step();
    idle_inputs();
    complete_range(6, 1);
`ifndef ROB_CDB_BYPASS_EN
    check("lat_ret_wait", bus.retire_valid, 3'b000);
    step();
`endif
    check("lat_ret", bus.retire_valid, 3'b001);
    step();
    check("lat_avail", bus.rob_avail_cnt, 64);
    ptr = 7;

    // Halt on lane 1: entries 7,8 retire, entry 9 never does.
    drive_alloc(3'b111, 1'b1, 3'b010);
    step();
    idle_inputs();
    complete_range(7, 3);
    for (int c = 0; c < 5 && bus.retire_valid == '0; c++) step();
    check("halt_ret", bus.retire_valid, 3'b011);
    check("halt_flag", bus.retire_halt, 1);
    repeat (3) step();
    check("halt_ret_stop", bus.retire_valid, 3'b000);
    check("halt_flag_off", bus.retire_halt, 0);
    check("halt_avail", bus.rob_avail_cnt, 63);
    check("halt_left", exp_q.size(), 1);
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
